// File: rtl/bcd_timekeeper_scan_pkg.sv
// Shared constants for the BCD timekeeper: active-low 7-segment glyphs and BCD limits.
// Pure declarations; no logic, no latency.
package bcd_timekeeper_scan_pkg;

  localparam logic [6:0] SEG_BLANK        = 7'h7F;
  localparam logic [6:0] SEG_ALL_ON       = 7'h00;
  localparam logic [3:0] BCD_DIGIT_MAX    = 4'd9;
  localparam int         PAIR_LIMIT_LOWER = 59;

  function automatic logic [7:0] to_bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bcd_timekeeper_scan_pair_counter.sv
// Two-digit BCD counter 00..LIMIT with parallel load, clear and ripple carry-out.
// Value registered one cycle after inc/clr/load; no backpressure.
module bcd_pair_counter
  import bcd_timekeeper_scan_pkg::*;
#(
  parameter int LIMIT = 59
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       inc,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic [7:0] value_nxt,
  output logic       at_max,
  output logic       carry
);

  localparam logic [7:0] MAX_BCD = to_bcd8(LIMIT);

  logic [7:0] value_q, value_d;

  assign at_max = (value_q == MAX_BCD);
  assign carry  = inc & at_max;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (clr) begin
      value_d = '0;
    end else if (inc) begin
      if (at_max) begin
        value_d = '0;
      end else if (value_q[3:0] == BCD_DIGIT_MAX) begin
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      end else begin
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) value_q <= '0;
    else         value_q <= value_d;
  end

  assign value     = value_q;
  assign value_nxt = value_d;

endmodule

// File: rtl/bcd_timekeeper_scan.sv
// BCD MM:SS / HH:MM:SS timekeeper with multiplexed 7-segment scan; alarm compare under ALARM_MATCH_EN.
// time_bcd, anode and seg are registered (1-cycle latency); no backpressure, loads always accepted or rejected.
module bcd_timekeeper_scan
  import bcd_timekeeper_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TOP_LIMIT  = 59,
  parameter int TICK_DIV   = 100000000,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    run,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic                    load_err,
  input  logic [NUM_DIGITS-1:0]   edit_sel,
  output logic [4*NUM_DIGITS-1:0] time_bcd,
  output logic                    wrap,
  input  logic                    alarm_en,
  input  logic [4*NUM_DIGITS-1:0] alarm_time,
  input  logic                    alarm_ack,
  output logic                    alarm_hit,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg
);

  localparam int         NUM_PAIRS = NUM_DIGITS / 2;
  localparam int         TW        = $clog2(TICK_DIV);
  localparam int         SW        = $clog2(SCAN_DIV + 1);
  localparam int         IW        = 3;
  localparam logic [7:0] TOP_BCD   = to_bcd8(TOP_LIMIT);
  localparam logic [7:0] LOWER_BCD = to_bcd8(PAIR_LIMIT_LOWER);

  logic [TW-1:0]           presc_q, presc_d, blink_q, blink_d;
  logic [SW-1:0]           scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]           scan_idx_q, scan_idx_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    load_err_q, load_err_d, wrap_q, wrap_d;
  logic                    tick, load_ok, load_apply, blink_phase, cur_edit;
  logic [7:0]              pair;
  logic [3:0]              cur_nib;
  logic [4*NUM_DIGITS-1:0] time_q, time_nxt;
  logic [NUM_PAIRS-1:0]    pair_inc, pair_max, pair_carry;
  logic                    unused_top_carry;

  // Load wins over tick, so a load cycle never also advances the time.
  assign tick = run & ~load & (presc_q == TW'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q;
    if (load)     presc_d = '0;
    else if (run) presc_d = (presc_q == TW'(TICK_DIV - 1)) ? '0 : presc_q + 1'b1;
  end

  // BCD byte order matches numeric order once both nibbles are <= 9.
  always_comb begin
    load_ok = 1'b1;
    pair    = '0;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      pair = load_value[8*p +: 8];
      if (pair[3:0] > BCD_DIGIT_MAX || pair[7:4] > BCD_DIGIT_MAX) load_ok = 1'b0;
      if (pair > ((p == NUM_PAIRS - 1) ? TOP_BCD : LOWER_BCD))     load_ok = 1'b0;
    end
  end

  assign load_apply = load & load_ok;
  assign load_err_d = load & ~load_ok;
  assign wrap_d     = tick & (&pair_max);
  assign pair_inc   = {pair_carry[NUM_PAIRS-2:0], tick};
  assign unused_top_carry = pair_carry[NUM_PAIRS-1];

  for (genvar g = 0; g < NUM_PAIRS; g++) begin : g_pair
    bcd_pair_counter #(
      .LIMIT((g == NUM_PAIRS - 1) ? TOP_LIMIT : PAIR_LIMIT_LOWER)
    ) u_pair (
      .clk      (clk),
      .resetn   (resetn),
      .inc      (pair_inc[g]),
      .clr      (wrap_d),
      .load     (load_apply),
      .load_val (load_value[8*g +: 8]),
      .value    (time_q[8*g +: 8]),
      .value_nxt(time_nxt[8*g +: 8]),
      .at_max   (pair_max[g]),
      .carry    (pair_carry[g])
    );
  end

`ifdef ALARM_MATCH_EN
  logic alarm_hit_q, alarm_hit_d;

  // A fresh match on the same cycle as an ack keeps the flag set.
  always_comb begin
    alarm_hit_d = alarm_hit_q & ~alarm_ack;
    if ((load_apply | tick) && alarm_en && (time_nxt == alarm_time)) alarm_hit_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) alarm_hit_q <= 1'b0;
    else         alarm_hit_q <= alarm_hit_d;
  end

  assign alarm_hit = alarm_hit_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_en, alarm_time, alarm_ack, time_nxt};
  assign alarm_hit    = 1'b0;
`endif

  always_comb begin
    scan_cnt_d = (scan_cnt_q == SW'(SCAN_DIV - 1)) ? '0 : scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_idx_d = (scan_idx_q == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
    end
    blink_d = (blink_q == TW'(TICK_DIV - 1)) ? '0 : blink_q + 1'b1;
  end

  assign blink_phase = (blink_q >= TW'(TICK_DIV / 2));

  // anode and seg come from the same index so they register together.
  always_comb begin
    cur_nib  = 4'hF;
    cur_edit = 1'b0;
    anode_d  = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_q == IW'(i)) begin
        cur_nib    = time_q[4*i +: 4];
        cur_edit   = edit_sel[i];
        anode_d[i] = 1'b0;
      end
    end
    if (alarm_hit)                                        seg_d = SEG_ALL_ON;
    else if (cur_nib > BCD_DIGIT_MAX || (cur_edit && blink_phase)) seg_d = SEG_BLANK;
    else                                                  seg_d = seg_glyph(cur_nib);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q    <= '0;
      blink_q    <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      anode_q    <= '1;
      seg_q      <= SEG_BLANK;
      load_err_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      blink_q    <= blink_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
      load_err_q <= load_err_d;
      wrap_q     <= wrap_d;
    end
  end

  assign time_bcd = time_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign anode    = anode_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_bcd_timekeeper_scan.sv
// Directed bench for bcd_timekeeper_scan at NUM_DIGITS=4, TOP_LIMIT=59, TICK_DIV=4, SCAN_DIV=2.
module tb_bcd_timekeeper_scan;

`ifdef ALARM_MATCH_EN
  localparam bit ALARM_ON = 1'b1;
`else
  localparam bit ALARM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        run = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = '0;
  logic [3:0]  edit_sel = '0;
  logic        alarm_en = 1'b0;
  logic [15:0] alarm_time = '0;
  logic        alarm_ack = 1'b0;
  logic        load_err, wrap, alarm_hit;
  logic [15:0] time_bcd;
  logic [3:0]  anode;
  logic [6:0]  seg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  bcd_timekeeper_scan #(
    .NUM_DIGITS(4), .TOP_LIMIT(59), .TICK_DIV(4), .SCAN_DIV(2)
  ) dut (
    .clk(clk), .resetn(resetn), .run(run), .load(load), .load_value(load_value),
    .load_err(load_err), .edit_sel(edit_sel), .time_bcd(time_bcd), .wrap(wrap),
    .alarm_en(alarm_en), .alarm_time(alarm_time), .alarm_ack(alarm_ack),
    .alarm_hit(alarm_hit), .anode(anode), .seg(seg)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; scan and blink counters both start from it.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  typedef struct {
    logic [15:0] val;
    logic        err;
    logic [15:0] t;
  } load_vec_t;

  load_vec_t lv [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'h7F;
    endcase
  endfunction

  task automatic check_disp(input string name, input logic [15:0] t, input logic [3:0] ed, input bit hit);
    int d;
    bit ph;
    logic [3:0] an;
    logic [3:0] nib;
    logic [6:0] sg;
    d   = ((cyc - 1) / 2) % 4;
    ph  = ((cyc - 1) % 4) >= 2;
    an  = 4'hF;
    an[d] = 1'b0;
    nib = t[d*4 +: 4];
    if (hit)                           sg = 7'h00;
    else if (nib > 4'd9 || (ed[d] && ph)) sg = 7'h7F;
    else                               sg = glyph(nib);
    check({name, " anode"}, 32'(anode), 32'(an));
    check({name, " seg"}, 32'(seg), 32'(sg));
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_value = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    lv[0] = '{16'h1234, 1'b0, 16'h1234};
    lv[1] = '{16'h0960, 1'b1, 16'h1234};
    lv[2] = '{16'h6000, 1'b1, 16'h1234};
    lv[3] = '{16'h5959, 1'b0, 16'h5959};
    lv[4] = '{16'h00A0, 1'b1, 16'h5959};
    lv[5] = '{16'h5A00, 1'b1, 16'h5959};
    lv[6] = '{16'h0000, 1'b0, 16'h0000};
    lv[7] = '{16'h5900, 1'b0, 16'h5900};

    // Reset state
    step();
    check("rst anode", 32'(anode), 32'hF);
    check("rst seg", 32'(seg), 32'h7F);
    check("rst time", 32'(time_bcd), 32'h0);
    check("rst alarm_hit", 32'(alarm_hit), 32'h0);
    check("rst wrap", 32'(wrap), 32'h0);
    check("rst load_err", 32'(load_err), 32'h0);
    resetn = 1'b1;
    step();
    check("post-rst anode", 32'(anode), 32'hE);
    check_disp("post-rst", 16'h0000, 4'b0000, 1'b0);

    // Load validation table
    for (int i = 0; i < 8; i++) begin
      do_load(lv[i].val);
      check($sformatf("load[%0d] err", i), 32'(load_err), 32'(lv[i].err));
      check($sformatf("load[%0d] time", i), 32'(time_bcd), 32'(lv[i].t));
      step();
      check($sformatf("load[%0d] err width", i), 32'(load_err), 32'h0);
    end
    repeat (8) step();
    check("run=0 hold", 32'(time_bcd), 32'h5900);

    // Counting, carry and wrap
    run = 1'b1;
    do_load(16'h5958);
    check("cnt load", 32'(time_bcd), 32'h5958);
    repeat (3) step();
    check("cnt pre-tick", 32'(time_bcd), 32'h5958);
    step();
    check("cnt 5959", 32'(time_bcd), 32'h5959);
    repeat (3) step();
    check("cnt 5959 hold", 32'(time_bcd), 32'h5959);
    check("wrap idle", 32'(wrap), 32'h0);
    step();
    check("cnt wrap time", 32'(time_bcd), 32'h0000);
    check("wrap pulse", 32'(wrap), 32'h1);
    step();
    check("wrap width", 32'(wrap), 32'h0);
    do_load(16'h0959);
    repeat (4) step();
    check("cnt ripple", 32'(time_bcd), 32'h1000);
    run = 1'b0;

    // Scan and blink
    do_load(16'h1234);
    step();
    foreach (lv[k]) begin
      if (k < 3) begin
        edit_sel = (k == 0) ? 4'b0000 : (k == 1) ? 4'b1010 : 4'b0001;
        step();
        for (int c = 0; c < 8; c++) begin
          step();
          check_disp($sformatf("scan e%0h c%0d", edit_sel, c), 16'h1234, edit_sel, 1'b0);
        end
      end
    end
    edit_sel = 4'b0000;
    do_load(16'h0000);
    do_load(16'h59A9);
    check("bad nibble reject", 32'(time_bcd), 32'h0000);

    // Alarm
    alarm_time = 16'h0003;
    alarm_en = 1'b1;
    run = 1'b1;
    do_load(16'h0001);
    check("alarm start", 32'(alarm_hit), 32'h0);
    repeat (7) step();
    check("alarm pre-match time", 32'(time_bcd), 32'h0002);
    check("alarm pre-match", 32'(alarm_hit), 32'h0);
    step();
    check("alarm match time", 32'(time_bcd), 32'h0003);
    check("alarm set", 32'(alarm_hit), 32'(ALARM_ON));
    run = 1'b0;
    step();
    check_disp("alarm disp", 16'h0003, 4'b0000, ALARM_ON);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    check("alarm ack", 32'(alarm_hit), 32'h0);
    step();
    check_disp("alarm cleared disp", 16'h0003, 4'b0000, 1'b0);
    alarm_ack = 1'b1;
    do_load(16'h0003);
    alarm_ack = 1'b0;
    check("alarm set beats ack", 32'(alarm_hit), 32'(ALARM_ON));
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0;
    alarm_en = 1'b0;
    do_load(16'h0003);
    check("alarm disarmed", 32'(alarm_hit), 32'h0);

    // Reset mid-operation kills a pending load_err pulse
    run = 1'b1;
    do_load(16'h0077);
    check("mid err pulse", 32'(load_err), 32'h1);
    resetn = 1'b0;
    #1;
    check("mid rst err", 32'(load_err), 32'h0);
    check("mid rst time", 32'(time_bcd), 32'h0);
    check("mid rst anode", 32'(anode), 32'hF);
    check("mid rst seg", 32'(seg), 32'h7F);
    run = 1'b0;
    step();
    resetn = 1'b1;
    step();
    check_disp("mid rst release", 16'h0000, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
